// File: rtl/sigma_delta_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sigma_delta_pkg : shared state encoding and command-phase constants   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package sigma_delta_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DRDY = 3'd1,
    ST_CMD_REQ   = 3'd2,
    ST_CMD_WAIT  = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_STORE     = 3'd6
  } state_t;

  localparam logic [5:0] CMD_LEN = 6'd8;

endpackage
`default_nettype wire

// File: rtl/sigma_delta_sample_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sigma_delta_sample_buf : one-entry sample buffer with overflow count  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module sigma_delta_sample_buf #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  store_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  overflow_o,
  output logic [7:0]            ovf_count_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            cnt_q, cnt_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = 1'b0;
    cnt_d   = cnt_q;
    if (valid_q && m_ready_i) valid_d = 1'b0;
    // A draining entry frees its slot in the same cycle the new sample lands.
    if (store_i) begin
      if (!valid_q || m_ready_i) begin
        valid_d = 1'b1;
        data_d  = sample_i;
      end else begin
        ovf_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_valid_o   = valid_q;
  assign m_data_o    = data_q;
  assign overflow_o  = ovf_q;
  assign ovf_count_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sigma_delta_acq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sigma_delta_acq_ctrl : continuous-read sequencer for a sigma-delta ADC|
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module sigma_delta_acq_ctrl
  import sigma_delta_pkg::*;
#(
  parameter int         DATA_WIDTH  = 24,
  parameter logic [7:0] READ_CMD    = 8'h58,
  parameter int         RSP_TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  data_ready,
  output logic                  spi_active,
  output logic                  cs_n,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic                  req_write,
  output logic [5:0]            req_len,
  output logic [7:0]            req_txdata,
  input  logic                  rsp_valid,
  input  logic [31:0]           rsp_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  overflow,
  output logic [7:0]            ovf_count,
  output logic                  timeout_err
);

  localparam int                CNT_W        = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LOAD = CNT_W'(RSP_TIMEOUT);
  localparam logic [5:0]        RD_LEN       = 6'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  tmo_q, tmo_d;
  logic                  en_q;
  logic                  cs_n_q, cs_n_d;
  logic                  store;
  logic                  unused_rsp_bits;

  assign unused_rsp_bits = ^rsp_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = TIMEOUT_LOAD;
    sample_d   = sample_q;
    tmo_d      = tmo_q;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_len    = 6'd0;
    req_txdata = 8'd0;
    store      = 1'b0;
    if (enable && !en_q) tmo_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_DRDY;
      end
      ST_WAIT_DRDY: begin
        if (!enable)         state_d = ST_IDLE;
        else if (data_ready) state_d = ST_CMD_REQ;
      end
      // An accepted request must be followed through, so the handshake wins over enable=0.
      ST_CMD_REQ: begin
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_len    = CMD_LEN;
        req_txdata = READ_CMD;
        if (req_ready)   state_d = ST_CMD_WAIT;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_CMD_WAIT: begin
        if (rsp_valid) begin
          state_d = ST_RD_REQ;
        end else if (cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RD_REQ: begin
        req_valid = 1'b1;
        req_len   = RD_LEN;
        if (req_ready)    state_d = ST_RD_WAIT;
        else if (!enable) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (rsp_valid) begin
          sample_d = rsp_data[DATA_WIDTH-1:0];
          state_d  = ST_STORE;
        end else if (cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STORE: begin
        store   = 1'b1;
        state_d = enable ? ST_WAIT_DRDY : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    cs_n_d = ~(enable || (state_d != ST_IDLE));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= TIMEOUT_LOAD;
      sample_q <= '0;
      tmo_q    <= 1'b0;
      en_q     <= 1'b0;
      cs_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      tmo_q    <= tmo_d;
      en_q     <= enable;
      cs_n_q   <= cs_n_d;
    end
  end

  assign spi_active  = (state_q == ST_CMD_REQ) || (state_q == ST_CMD_WAIT) ||
                       (state_q == ST_RD_REQ)  || (state_q == ST_RD_WAIT)  ||
                       (state_q == ST_STORE);
  assign cs_n        = cs_n_q;
  assign timeout_err = tmo_q;

  sigma_delta_sample_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk         (clk),
    .resetn      (resetn),
    .store_i     (store),
    .sample_i    (sample_q),
    .m_ready_i   (m_ready),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data),
    .overflow_o  (overflow),
    .ovf_count_o (ovf_count)
  );

endmodule
`default_nettype wire
